// File: rtl/clk_gen.sv
// Programmable glitch-free clock divider with registered clk_out and optional edge strobes.
// Define CLK_GEN_STROBE_EN to build the rise_stb/fall_stb registers; otherwise both are tied to 0.
module clk_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 clk_out,
    output logic                 running,
    output logic                 rise_stb,
    output logic                 fall_stb
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_q;
    logic                 r_clk_out;
    logic [DIV_WIDTH-1:0] w_cnt_nxt;
    logic [DIV_WIDTH-1:0] w_div_q_nxt;
    logic                 w_clk_out_nxt;
    logic [DIV_WIDTH-1:0] w_div_eff;
    logic [DIV_WIDTH-1:0] w_cnt_inc;
    logic [DIV_WIDTH-1:0] w_high;
    logic                 w_period_end;
    logic                 w_start;

    // Ratios below 2 cannot form a high and a low phase, so they saturate to 2.
    assign w_div_eff    = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;
    assign w_cnt_inc    = r_cnt + DIV_WIDTH'(1);
    assign w_high       = r_div_q >> 1;
    assign w_period_end = (r_state == S_RUN) && (r_cnt == r_div_q - DIV_WIDTH'(1));
    assign w_start      = en && ((r_state == S_IDLE) || w_period_end);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (en) w_state_nxt = S_RUN;
        end else begin
            if (w_period_end && !en) w_state_nxt = S_IDLE;
        end
    end

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_div_q_nxt   = r_div_q;
        w_clk_out_nxt = r_clk_out;
        if (w_start) begin
            w_cnt_nxt     = '0;
            w_div_q_nxt   = w_div_eff;
            w_clk_out_nxt = 1'b1;
        end else if (w_period_end) begin
            w_cnt_nxt     = '0;
            w_clk_out_nxt = 1'b0;
        end else if (r_state == S_RUN) begin
            w_cnt_nxt     = w_cnt_inc;
            w_clk_out_nxt = (w_cnt_inc < w_high);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_div_q   <= DIV_WIDTH'(2);
            r_clk_out <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_div_q   <= w_div_q_nxt;
            r_clk_out <= w_clk_out_nxt;
        end
    end

    assign clk_out = r_clk_out;
    assign running = (r_state == S_RUN);

`ifdef CLK_GEN_STROBE_EN
    logic r_rise_stb;
    logic r_fall_stb;

    // Strobes are derived from the clk_out transition so they line up with its first high/low cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rise_stb <= 1'b0;
            r_fall_stb <= 1'b0;
        end else begin
            r_rise_stb <= w_clk_out_nxt & ~r_clk_out;
            r_fall_stb <= ~w_clk_out_nxt & r_clk_out;
        end
    end

    assign rise_stb = r_rise_stb;
    assign fall_stb = r_fall_stb;
`else
    assign rise_stb = 1'b0;
    assign fall_stb = 1'b0;
`endif

endmodule

// File: tb/tb_clk_gen.sv
// Directed self-checking bench for clk_gen; strobe expectations follow CLK_GEN_STROBE_EN.
module tb_clk_gen;
    localparam int W = 8;
`ifdef CLK_GEN_STROBE_EN
    localparam logic STB = 1'b1;
`else
    localparam logic STB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div;
    logic         clk_out;
    logic         running;
    logic         rise_stb;
    logic         fall_stb;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    clk_gen #(.DIV_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div      (div),
        .clk_out  (clk_out),
        .running  (running),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Outputs are packed as {clk_out, running, rise_stb, fall_stb} and sampled on the falling edge.
    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b0; en = 1'b1; div = W'(4);
        #12;
        checks++;
        if ({clk_out, running, rise_stb, fall_stb} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold: got %b want %b", {clk_out, running, rise_stb, fall_stb}, 4'b0000);
        end
        rst = 1'b1;
        @(negedge clk);
        exp = {1'b1, 1'b1, STB, 1'b0};
        checks++;
        if ({clk_out, running, rise_stb, fall_stb} !== exp) begin
            failures++;
            $display("FAIL reset_release_rise: got %b want %b", {clk_out, running, rise_stb, fall_stb}, exp);
        end
    endtask

    task automatic test_div4();
        logic [0:10] ck = 11'b10011001100;
        logic        prev = 1'b1;
        logic [3:0]  exp;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            exp = {ck[i], 1'b1, STB & ck[i] & ~prev, STB & ~ck[i] & prev};
            checks++;
            if ({clk_out, running, rise_stb, fall_stb} !== exp) begin
                failures++;
                $display("FAIL div4 edge %0d: got %b want %b", i, {clk_out, running, rise_stb, fall_stb}, exp);
            end
            prev = ck[i];
        end
    endtask

    task automatic go_idle();
        en = 1'b0;
        for (int i = 0; i < 64 && running !== 1'b0; i++) @(negedge clk);
        checks++;
        if ({clk_out, running} !== 2'b00) begin
            failures++;
            $display("FAIL go_idle: got %b want %b", {clk_out, running}, 2'b00);
        end
    endtask

    task automatic test_odd_sat();
        logic [0:9]   pat [3] = '{10'b1100011000, 10'b1010101010, 10'b1010101010};
        logic [W-1:0] dv  [3] = '{W'(5), W'(0), W'(1)};
        logic [0:9]   ck;
        logic         prev;
        logic [3:0]   exp;
        for (int r = 0; r < 3; r++) begin
            go_idle();
            div  = dv[r];
            en   = 1'b1;
            ck   = pat[r];
            prev = 1'b0;
            for (int i = 0; i <= 9; i++) begin
                @(negedge clk);
                exp = {ck[i], 1'b1, STB & ck[i] & ~prev, STB & ~ck[i] & prev};
                checks++;
                if ({clk_out, running, rise_stb, fall_stb} !== exp) begin
                    failures++;
                    $display("FAIL odd_sat div=%0d edge %0d: got %b want %b", dv[r], i,
                             {clk_out, running, rise_stb, fall_stb}, exp);
                end
                prev = ck[i];
            end
        end
    endtask

    task automatic test_ratio_change();
        logic [0:10] ck = 11'b11001110001;
        logic        prev = 1'b0;
        logic [3:0]  exp;
        go_idle();
        div = W'(4);
        en  = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            exp = {ck[i], 1'b1, STB & ck[i] & ~prev, STB & ~ck[i] & prev};
            checks++;
            if ({clk_out, running, rise_stb, fall_stb} !== exp) begin
                failures++;
                $display("FAIL ratio_change edge %0d: got %b want %b", i, {clk_out, running, rise_stb, fall_stb}, exp);
            end
            prev = ck[i];
            if (i == 0) div = W'(6);
        end
    endtask

    task automatic test_gated_stop();
        logic [0:11] env = 12'b100000101111;
        logic [0:11] ck  = 12'b110000110011;
        logic [0:11] rn  = 12'b111100111111;
        logic        prev = 1'b0;
        logic [3:0]  exp;
        go_idle();
        div = W'(4);
        for (int i = 0; i <= 11; i++) begin
            en = env[i];
            @(negedge clk);
            exp = {ck[i], rn[i], STB & ck[i] & ~prev, STB & ~ck[i] & prev};
            checks++;
            if ({clk_out, running, rise_stb, fall_stb} !== exp) begin
                failures++;
                $display("FAIL gated_stop edge %0d: got %b want %b", i, {clk_out, running, rise_stb, fall_stb}, exp);
            end
            prev = ck[i];
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp;
        go_idle();
        div = W'(4);
        en  = 1'b1;
        @(negedge clk);
        exp = {1'b1, 1'b1, STB, 1'b0};
        checks++;
        if ({clk_out, running, rise_stb, fall_stb} !== exp) begin
            failures++;
            $display("FAIL async_pre_high: got %b want %b", {clk_out, running, rise_stb, fall_stb}, exp);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({clk_out, running, rise_stb, fall_stb} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset: got %b want %b", {clk_out, running, rise_stb, fall_stb}, 4'b0000);
        end
        @(negedge clk);
        checks++;
        if ({clk_out, running, rise_stb, fall_stb} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset_hold: got %b want %b", {clk_out, running, rise_stb, fall_stb}, 4'b0000);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({clk_out, running, rise_stb, fall_stb} !== exp) begin
            failures++;
            $display("FAIL async_post_rise: got %b want %b", {clk_out, running, rise_stb, fall_stb}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_div4();
        test_odd_sat();
        test_ratio_change();
        test_gated_stop();
        test_async_reset();
        go_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1);
    end

endmodule
